// File: rtl/ddr_bw_pkg.sv
// Shared types, AXI constants and helpers for the DDR read-bandwidth engine.
package ddr_bw_pkg;

    typedef enum logic [1:0] {
        IDLE_ST = 2'd0,
        RUN_ST  = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    localparam int unsigned BURST_BEATS    = 8;
    localparam int unsigned BURST_BYTES    = 64;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

    localparam logic [7:0]  AXI_LEN   = 8'(BURST_BEATS - 1);
    localparam logic [2:0]  AXI_SIZE  = 3'($clog2(BURST_BYTES / BURST_BEATS));
    localparam logic [2:0]  LAST_BEAT = 3'(BURST_BEATS - 1);

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ddr_rd_engine.sv
// AXI read bandwidth engine: issues NBURST 8-beat INCR bursts from a 64-byte
// aligned base, keeps at most MAX_OUTST in flight, and counts cycles/beats/errors.
module ddr_rd_engine
    import ddr_bw_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        START_REG,
    input  logic [31:0] ADDR_REG,
    input  logic [31:0] NBURST_REG,
    output logic        IDLE_REG,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [63:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [63:0] rd_data,
    output logic        rd_valid,
    output logic [31:0] cnt_cycles,
    output logic [31:0] cnt_beats,
    output logic        err
);

    localparam int unsigned OFFS_W = $clog2(BURST_BYTES);
    localparam int unsigned BASE_W = 32 - OFFS_W;
    localparam logic [3:0]  MAX_O  = 4'(MAX_OUTST);

    state_t              state, state_nxt;
    logic                start_d, start_edge;
    logic [BASE_W-1:0]   base;
    logic [15:0]         nburst, issued, completed;
    logic [15:0]         issued_nxt, completed_nxt;
    logic [3:0]          outst, outst_nxt;
    logic [2:0]          beat_cnt;
    logic [31:0]         cycles_q, beats_q;
    logic                err_q;
    logic                arvalid_q, arvalid_nxt;
    logic [31:0]         araddr_q, araddr_nxt;
    logic [63:0]         rd_data_q;
    logic                rd_valid_q;
    logic                ar_hs, r_acc, r_hs, r_stray, rlast_hs;
    logic                can_issue, beat_err, resp_err;
    logic                unused_bits;

    assign unused_bits = ^{NBURST_REG[31:16], ADDR_REG[OFFS_W-1:0]};

    assign start_edge   = START_REG & ~start_d;
    assign m_axi_rready = ~rst;

    assign ar_hs    = arvalid_q & m_axi_arready;
    assign r_acc    = (state == RUN_ST) & m_axi_rvalid & m_axi_rready;
    // Beats with nothing outstanding are flagged and dropped, never counted.
    assign r_hs     = r_acc & (outst != '0);
    assign r_stray  = r_acc & (outst == '0);
    assign rlast_hs = r_hs & m_axi_rlast;

    assign issued_nxt    = issued + 16'(ar_hs);
    assign completed_nxt = completed + 16'(rlast_hs);

    always_comb begin
        outst_nxt = outst;
        case ({ar_hs, rlast_hs})
            2'b10:   outst_nxt = outst + 4'd1;
            2'b01:   outst_nxt = outst - 4'd1;
            default: outst_nxt = outst;
        endcase
    end

    assign can_issue = (issued_nxt < nburst) && (outst_nxt < MAX_O);

    assign beat_err = r_hs & (m_axi_rlast ? (beat_cnt != LAST_BEAT)
                                          : (beat_cnt == LAST_BEAT));
    assign resp_err = r_hs & (m_axi_rresp != AXI_RESP_OKAY);

    always_comb begin
        state_nxt   = state;
        arvalid_nxt = 1'b0;
        araddr_nxt  = araddr_q;
        case (state)
            IDLE_ST: begin
                if (start_edge) state_nxt = RUN_ST;
            end
            RUN_ST: begin
                if (completed_nxt == nburst) begin
                    state_nxt = DONE_ST;
                end else if (arvalid_q && !m_axi_arready) begin
                    arvalid_nxt = 1'b1;
                end else if (can_issue) begin
                    // Next address uses the post-handshake issue count so
                    // back-to-back bursts need no idle cycle.
                    arvalid_nxt = 1'b1;
                    araddr_nxt  = {base + BASE_W'(issued_nxt), {OFFS_W{1'b0}}};
                end
            end
            DONE_ST: state_nxt = IDLE_ST;
            default: state_nxt = IDLE_ST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE_ST;
            start_d    <= 1'b0;
            base       <= '0;
            nburst     <= '0;
            issued     <= '0;
            completed  <= '0;
            outst      <= '0;
            beat_cnt   <= '0;
            cycles_q   <= '0;
            beats_q    <= '0;
            err_q      <= 1'b0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            start_d    <= START_REG;
            arvalid_q  <= arvalid_nxt;
            araddr_q   <= araddr_nxt;
            rd_valid_q <= r_hs;
            if (r_hs) rd_data_q <= m_axi_rdata;

            if (state == IDLE_ST && start_edge) begin
                base      <= ADDR_REG[31:OFFS_W];
                nburst    <= NBURST_REG[15:0];
                issued    <= '0;
                completed <= '0;
                outst     <= '0;
                beat_cnt  <= '0;
                cycles_q  <= '0;
                beats_q   <= '0;
                err_q     <= 1'b0;
            end else if (state == RUN_ST) begin
                issued    <= issued_nxt;
                completed <= completed_nxt;
                outst     <= outst_nxt;
                cycles_q  <= sat_inc32(cycles_q);
                if (r_hs) begin
                    beats_q  <= sat_inc32(beats_q);
                    beat_cnt <= m_axi_rlast ? 3'd0 : beat_cnt + 3'd1;
                end
                if (beat_err || resp_err || r_stray) err_q <= 1'b1;
            end
        end
    end

    assign IDLE_REG      = (state == IDLE_ST);
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_arlen   = AXI_LEN;
    assign m_axi_arsize  = AXI_SIZE;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign cnt_cycles    = cycles_q;
    assign cnt_beats     = beats_q;
    assign err           = err_q;

endmodule

// File: tb/tb_ddr_rd_engine.sv
// Directed bench for ddr_rd_engine: table of runs against a negedge AXI slave
// model, plus hand sequences for NBURST=0, ignored starts and mid-run reset.
module tb_ddr_rd_engine;

    localparam int unsigned MAX_OUTST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        START_REG;
    logic [31:0] ADDR_REG, NBURST_REG;
    logic        IDLE_REG;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid, m_axi_arready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic [31:0] cnt_cycles, cnt_beats;
    logic        err;

    always #5 clk = ~clk;

    ddr_rd_engine #(.MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .rst(rst), .START_REG(START_REG), .ADDR_REG(ADDR_REG),
        .NBURST_REG(NBURST_REG), .IDLE_REG(IDLE_REG),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .rd_data(rd_data), .rd_valid(rd_valid),
        .cnt_cycles(cnt_cycles), .cnt_beats(cnt_beats), .err(err)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Slave model state (owned by the negedge process, configured at posedge+1)
    int unsigned cyc = 0;
    int          ar_wait_cfg = 0, r_delay_cfg = 0, mode_cfg = 0;
    int unsigned burst_time_q[$];
    logic [63:0] exp_rd_q[$];
    int          beat_idx = 0, ar_wait_cnt = 0;
    logic        prev_ar_hs = 0, prev_ar_wait = 0, prev_r_hs = 0, prev_r_last = 0;
    logic        prev_r_stray = 0, stray_flag = 0, stray_pending = 0;
    logic [31:0] prev_araddr = '0;
    logic [63:0] prev_rdata = '0, data_seq = 64'h0123_4567_0000_0000;
    int          ar_count = 0, outst_b = 0, peak = 0, hold_bad = 0, rd_bad = 0;
    int          rd_count = 0, idle_low_cnt = 0, arvalid_seen = 0, attr_bad = 0;
    logic [31:0] first_addr = '0, last_addr = '0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                burst_time_q.delete();
                exp_rd_q.delete();
                m_axi_arready = 1'b0;
                m_axi_rvalid  = 1'b0;
                m_axi_rlast   = 1'b0;
                beat_idx = 0; ar_wait_cnt = 0; outst_b = 0;
                prev_ar_hs = 0; prev_ar_wait = 0; prev_r_hs = 0; prev_r_stray = 0;
            end else begin
                if (prev_r_hs && !prev_r_stray) begin
                    exp_rd_q.push_back(prev_rdata);
                    if (prev_r_last) begin
                        outst_b--;
                        void'(burst_time_q.pop_front());
                        beat_idx = 0;
                    end else begin
                        beat_idx++;
                    end
                end
                if (prev_ar_hs) begin
                    ar_count++;
                    if (ar_count == 1) first_addr = prev_araddr;
                    last_addr = prev_araddr;
                    outst_b++;
                    if (outst_b > peak) peak = outst_b;
                    burst_time_q.push_back(cyc + r_delay_cfg);
                end
                if (prev_ar_wait && (m_axi_arvalid !== 1'b1 || m_axi_araddr !== prev_araddr))
                    hold_bad++;
                if (rd_valid === 1'b1) begin
                    rd_count++;
                    if (exp_rd_q.size() == 0) rd_bad++;
                    else if (rd_data !== exp_rd_q.pop_front()) rd_bad++;
                end
                if (IDLE_REG === 1'b0) idle_low_cnt++;
                if (m_axi_arvalid === 1'b1) begin
                    arvalid_seen++;
                    if (m_axi_arlen !== 8'd7 || m_axi_arsize !== 3'd3 || m_axi_arburst !== 2'b01)
                        attr_bad++;
                end

                if (m_axi_arvalid === 1'b1 && ar_wait_cnt >= ar_wait_cfg) begin
                    m_axi_arready = 1'b1;
                end else begin
                    m_axi_arready = 1'b0;
                    if (m_axi_arvalid === 1'b1) ar_wait_cnt++;
                end

                if (stray_pending && IDLE_REG === 1'b0 && outst_b == 0) begin
                    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
                    m_axi_rdata  = 64'hDEAD_BEEF_0BAD_0BAD;
                    stray_flag = 1'b1; stray_pending = 1'b0;
                end else if (burst_time_q.size() > 0 && burst_time_q[0] <= cyc) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = data_seq;
                    data_seq     = data_seq + 64'h0000_0001_0001_0003;
                    m_axi_rlast  = (beat_idx == ((mode_cfg == 1) ? 6 : 7));
                    m_axi_rresp  = (mode_cfg == 2 && beat_idx == 0) ? 2'b10 : 2'b00;
                    stray_flag   = 1'b0;
                end else begin
                    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; stray_flag = 1'b0;
                end

                prev_ar_hs   = m_axi_arvalid && m_axi_arready;
                prev_ar_wait = m_axi_arvalid && !m_axi_arready;
                prev_araddr  = m_axi_araddr;
                prev_r_hs    = m_axi_rvalid && m_axi_rready;
                prev_r_last  = m_axi_rlast;
                prev_r_stray = stray_flag;
                prev_rdata   = m_axi_rdata;
                if (prev_ar_hs) ar_wait_cnt = 0;
            end
        end
    end

    task automatic kick(input logic [31:0] addr, input logic [31:0] nb,
                        input int aw, input int rd, input int md);
        @(posedge clk); #1;
        ar_count = 0; peak = 0; hold_bad = 0; rd_bad = 0; rd_count = 0;
        idle_low_cnt = 0; arvalid_seen = 0; attr_bad = 0;
        ar_wait_cfg = aw; r_delay_cfg = rd; mode_cfg = md; stray_pending = (md == 3);
        START_REG = 1'b1; ADDR_REG = addr; NBURST_REG = nb;
        @(posedge clk); #1;
        START_REG = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (IDLE_REG === 1'b1) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check({name, "_done"}, 64'(ok), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] nburst;
        int          ar_wait;
        int          r_delay;
        int          mode;       // 0 clean, 1 rlast on beat 7, 2 rresp SLVERR, 3 stray beat
        int          exp_ars;
        int          exp_beats;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        logic        exp_err;
        int          exp_peak;   // 0: only the MAX_OUTST bound is checked
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; START_REG = 1'b0; ADDR_REG = '0; NBURST_REG = '0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        m_axi_rresp = 2'b00; m_axi_rdata = '0;

        vecs[0] = '{32'h1000_0040, 32'd4,          0,  0, 0,  4, 32, 32'h1000_0040, 32'h1000_0100, 1'b0, 4};
        vecs[1] = '{32'h1000_0000, 32'd10,         5, 20, 0, 10, 80, 32'h1000_0000, 32'h1000_0240, 1'b0, 4};
        vecs[2] = '{32'h2000_0000, 32'h0001_0003,  0,  0, 1,  3, 21, 32'h2000_0000, 32'h2000_0080, 1'b1, 0};
        vecs[3] = '{32'h3000_0000, 32'd3,          0,  0, 2,  3, 24, 32'h3000_0000, 32'h3000_0080, 1'b1, 0};
        vecs[4] = '{32'hFFFF_FFC0, 32'd2,          0,  0, 0,  2, 16, 32'hFFFF_FFC0, 32'h0000_0000, 1'b0, 0};
        vecs[5] = '{32'h2000_003F, 32'd1,          2,  3, 0,  1,  8, 32'h2000_0000, 32'h2000_0000, 1'b0, 1};
        vecs[6] = '{32'h4000_0000, 32'd2,          5,  0, 3,  2, 16, 32'h4000_0000, 32'h4000_0040, 1'b1, 0};
        vecs[7] = '{32'h5000_1234, 32'd4,          1,  2, 0,  4, 32, 32'h5000_1200, 32'h5000_12C0, 1'b0, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_idle",    64'(IDLE_REG), 64'd1);
        check("rst_rready",  64'(m_axi_rready), 64'd0);
        check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_rdvalid", 64'(rd_valid), 64'd0);
        check("rst_err",     64'(err), 64'd0);
        check("rst_cycles",  64'(cnt_cycles), 64'd0);
        check("rst_beats",   64'(cnt_beats), 64'd0);
        check("rst_rddata",  rd_data, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rready_up", 64'(m_axi_rready), 64'd1);

        for (int v = 0; v < 8; v++) begin
            string tag;
            tag = $sformatf("v%0d", v);
            kick(vecs[v].addr, vecs[v].nburst, vecs[v].ar_wait, vecs[v].r_delay, vecs[v].mode);
            wait_idle(tag);
            check({tag, "_ars"},     64'(ar_count),  64'(vecs[v].exp_ars));
            check({tag, "_beats"},   64'(cnt_beats), 64'(vecs[v].exp_beats));
            check({tag, "_first"},   64'(first_addr), 64'(vecs[v].exp_first));
            check({tag, "_last"},    64'(last_addr),  64'(vecs[v].exp_last));
            check({tag, "_err"},     64'(err),       64'(vecs[v].exp_err));
            check({tag, "_rdcnt"},   64'(rd_count),  64'(vecs[v].exp_beats));
            check({tag, "_rddata"},  64'(rd_bad),    64'd0);
            check({tag, "_hold"},    64'(hold_bad),  64'd0);
            check({tag, "_attr"},    64'(attr_bad),  64'd0);
            check({tag, "_outmax"},  64'(peak <= int'(MAX_OUTST)), 64'd1);
            check({tag, "_cycles"},  64'(cnt_cycles), 64'(idle_low_cnt - 1));
            check({tag, "_arv_idle"}, 64'(m_axi_arvalid), 64'd0);
            if (vecs[v].exp_peak != 0)
                check({tag, "_peak"}, 64'(peak), 64'(vecs[v].exp_peak));
        end

        // Empty run: one RUN cycle, one DONE cycle, no AR traffic.
        kick(32'h6000_0000, 32'd0, 0, 0, 0);
        wait_idle("nb0");
        check("nb0_idle_low", 64'(idle_low_cnt), 64'd2);
        check("nb0_arvalid",  64'(arvalid_seen), 64'd0);
        check("nb0_cycles",   64'(cnt_cycles), 64'd1);
        check("nb0_beats",    64'(cnt_beats), 64'd0);
        check("nb0_err",      64'(err), 64'd0);

        // Reset during the third burst aborts the run immediately.
        kick(32'h7000_0000, 32'd8, 0, 0, 0);
        begin
            bit reached = 0;
            for (int i = 0; i < 500; i++) begin
                if (rd_count >= 19) begin reached = 1; break; end
                @(posedge clk); #1;
            end
            check("mid_reach", 64'(reached), 64'd1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_idle",    64'(IDLE_REG), 64'd1);
        check("mid_rst_rready",  64'(m_axi_rready), 64'd0);
        check("mid_rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("mid_rst_beats",   64'(cnt_beats), 64'd0);
        check("mid_rst_cycles",  64'(cnt_cycles), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Restart; a second start edge while running must be ignored.
        kick(32'h7100_0000, 32'd3, 0, 4, 0);
        repeat (3) @(posedge clk);
        #1;
        START_REG = 1'b1; NBURST_REG = 32'd9; ADDR_REG = 32'h7200_0000;
        @(posedge clk); #1;
        START_REG = 1'b0;
        wait_idle("restart");
        check("restart_ars",    64'(ar_count), 64'd3);
        check("restart_first",  64'(first_addr), 64'h7100_0000);
        check("restart_beats",  64'(cnt_beats), 64'd24);
        check("restart_rdcnt",  64'(rd_count), 64'd24);
        check("restart_rddata", 64'(rd_bad), 64'd0);
        check("restart_err",    64'(err), 64'd0);
        check("restart_cycles", 64'(cnt_cycles), 64'(idle_low_cnt - 1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
